// File: rtl/shift_seq_pkg.sv
// Shared constants for the Shift_32 sequencer: register mode codes, op codes
// and controller state encoding.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SRL  = 3'b010,
    OP_SRA  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Reserved codes and NOP issue no shift clocks.
  function automatic logic op_shifts(input logic [2:0] op);
    return (op != 3'b000) && (op <= 3'b101);
  endfunction

  function automatic logic op_is_left(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shift_amt_cnt.sv
// Loadable down-counter holding the remaining number of shift clocks.
module shift_amt_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] val_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (dec_i)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer driving a 74LS194-chain shift register: optional parallel load,
// then an exact number of shift clocks with the serial input chosen by op.
//
// state | meaning
// IDLE  | waiting for start, register held
// LOAD  | one cycle of parallel load from PData
// SHIFT | shifting, counter holds shifts still to issue
// DONE  | register held, done pulse
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  input  logic          ld,
  input  logic [2:0]    op,
  input  logic [CW-1:0] amt,
  input  logic [W-1:0]  din,
  input  logic [W-1:0]  q_in,
  output logic          S1,
  output logic          S0,
  output logic          SR,
  output logic          SL,
  output logic [W-1:0]  PData,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  pdata_q, pdata_d;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0] cnt_val;
  mode_e         mode;

  // Only the end bits of q_in are serial feedback.
  logic unused_q_mid;
  assign unused_q_mid = ^q_in[W-2:1];

  shift_amt_cnt #(.CW(CW)) u_cnt (
    .clk    (clk),
    .clear  (clear),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (amt),
    .cnt_o  (cnt_val),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pdata_d  = pdata_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = op;
          pdata_d  = din;
          cnt_load = 1'b1;
          if (ld)
            state_d = ST_LOAD;
          else if ((amt != '0) && op_shifts(op))
            state_d = ST_SHIFT;
          else
            state_d = ST_DONE;
        end
      end
      ST_LOAD: begin
        if ((cnt_val != '0) && op_shifts(op_q))
          state_d = ST_SHIFT;
        else
          state_d = ST_DONE;
      end
      ST_SHIFT: begin
        cnt_dec = 1'b1;
        if (cnt_last)
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      pdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pdata_q <= pdata_d;
    end
  end

  always_comb begin
    mode = MODE_HOLD;
    SR   = 1'b0;
    SL   = 1'b0;
    case (state_q)
      ST_LOAD:  mode = MODE_LOAD;
      ST_SHIFT: begin
        mode = op_is_left(op_q) ? MODE_SHL : MODE_SHR;
        case (op_q)
          OP_SRA:  SR = q_in[W-1];
          OP_ROR:  SR = q_in[0];
          OP_ROL:  SL = q_in[W-1];
          default: ;
        endcase
      end
      default: mode = MODE_HOLD;
    endcase
  end

  assign {S1, S0} = mode;
  assign PData    = pdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule
